// File: rtl/pmem_pkg.sv
// Shared constants and FSM state type for the pmem responder.
package pmem_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

endpackage

// File: rtl/pmem_responder_if.sv
// Cache-to-memory line bus: the cache is master, the responder is slave.
interface pmem_responder_if;
  import pmem_pkg::*;

  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              pmem_err;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_err
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_err
  );

endinterface

// File: rtl/pmem_line_store.sv
// Backing store of DEPTH_LINES full cache lines: one synchronous write port,
// one combinational read port, every line cleared by reset.
module pmem_line_store
  import pmem_pkg::*;
#(
  parameter  int unsigned DEPTH_LINES = 16,
  localparam int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [DEPTH_LINES];

  // NOTE: reset clears every line, so this array maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_LINES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder: IDLE/BUSY/RESP FSM over pmem_line_store.
// Defining PMEM_RESPONDER_CHECK_EN adds a sticky protocol checker on pmem_err.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_LINES = 16
) (
  input logic             clk,
  input logic             rst,
  pmem_responder_if.slave bus
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  pmem_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_is_write;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata;
  logic              r_resp;

  logic              w_req;
  logic              w_store_we;
  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [LINE_W-1:0] w_line;

  assign w_req      = bus.pmem_read | bus.pmem_write;
  assign w_req_idx  = bus.pmem_address[OFFSET_W +: IDX_W];
  // In IDLE the read port follows the incoming address so a LATENCY==1 read fetches on acceptance.
  assign w_rd_idx   = (r_state == IDLE) ? w_req_idx : r_idx;
  assign w_store_we = (r_state == RESP) && r_is_write;

  pmem_line_store #(
    .DEPTH_LINES (DEPTH_LINES)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_store_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_line)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_resp     <= 1'b0;
    end else begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx      <= w_req_idx;
            r_is_write <= bus.pmem_write;
            r_wdata    <= bus.pmem_wdata;
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_cnt   <= '0;
              r_resp  <= 1'b1;
              r_rdata <= bus.pmem_write ? '0 : w_line;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt < CNT_W'(2)) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
            r_rdata <= r_is_write ? '0 : w_line;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pmem_resp  = r_resp;
  assign bus.pmem_rdata = r_rdata;

`ifdef PMEM_RESPONDER_CHECK_EN
  logic [31:0] r_chk_addr;
  logic        r_err;
  logic        w_viol;

  // Read-side wdata is a don't-care, so it is only compared for latched writes.
  always_comb begin
    w_viol = bus.pmem_read & bus.pmem_write;
    if ((r_state == IDLE) && w_req && (bus.pmem_address[OFFSET_W-1:0] != '0)) begin
      w_viol = 1'b1;
    end
    if ((r_state == BUSY) &&
        ((bus.pmem_address != r_chk_addr) ||
         (bus.pmem_write != r_is_write) ||
         (bus.pmem_read == r_is_write) ||
         (r_is_write && (bus.pmem_wdata != r_wdata)))) begin
      w_viol = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chk_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_req) begin
        r_chk_addr <= bus.pmem_address;
      end
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.pmem_err = r_err;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.pmem_address[31:OFFSET_W+IDX_W], bus.pmem_address[OFFSET_W-1:0]};
  assign bus.pmem_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: LATENCY=4 instance for the main table and
// corner sequences, LATENCY=1 instance for the short-latency path.
module tb_pmem_responder;

`ifdef PMEM_RESPONDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [255:0] PAT_DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] PAT_B  = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] PAT_C  = {32{8'hA5}};
  localparam logic [255:0] PAT_D  = {8{32'h12345678}};
  localparam logic [255:0] PAT_E  = {16{16'hBEEF}};
  localparam logic [255:0] PAT_F  = {8{32'hF00DCAFE}};
  localparam logic [255:0] PAT_G  = {8{32'h0BADF00D}};
  localparam logic [255:0] PAT_H  = {8{32'h55AA33CC}};
  localparam logic [255:0] PAT_P  = {8{32'hCAFEBABE}};

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pmem_responder_if bus4 ();
  pmem_responder_if bus1 ();

  pmem_responder #(.LATENCY(4), .DEPTH_LINES(16)) u_dut4 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus4)
  );

  pmem_responder #(.LATENCY(1), .DEPTH_LINES(16)) u_dut1 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? bus1.pmem_resp : bus4.pmem_resp;
  endfunction

  function automatic logic [255:0] get_rdata(input bit sel);
    return sel ? bus1.pmem_rdata : bus4.pmem_rdata;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus1.pmem_err : bus4.pmem_err;
  endfunction

  task automatic drive(input bit sel, input bit wr, input bit rd,
                       input logic [31:0] a, input logic [255:0] d);
    if (sel) begin
      bus1.pmem_write = wr; bus1.pmem_read = rd; bus1.pmem_address = a; bus1.pmem_wdata = d;
    end else begin
      bus4.pmem_write = wr; bus4.pmem_read = rd; bus4.pmem_address = a; bus4.pmem_wdata = d;
    end
  endtask

  task automatic check_quiet(input bit sel, input string name);
    check({name, " resp"}, 256'(get_resp(sel)), 256'(0));
    check({name, " rdata"}, get_rdata(sel), '0);
    check({name, " err"}, 256'(get_err(sel)), 256'(0));
  endtask

  // Waits, from the current negedge, for pmem_resp; latency counts rising edges.
  task automatic wait_resp(input bit sel, input int exp_lat, input logic [255:0] exp_rd,
                           input bit exp_err, input string name);
    int k;
    bit got;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (get_resp(sel)) begin
        got = 1'b1;
        check({name, " latency"}, 256'(k), 256'(exp_lat));
        check({name, " rdata"}, get_rdata(sel), exp_rd);
        check({name, " err"}, 256'(get_err(sel)), 256'(exp_err));
      end else begin
        check({name, " rdata outside resp"}, get_rdata(sel), '0);
      end
    end
    check({name, " resp seen"}, 256'(got), 256'(1));
  endtask

  task automatic do_txn(input bit sel, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [255:0] d, input logic [255:0] exp_rd,
                        input bit exp_err, input string name);
    drive(sel, wr, rd, a, d);
    wait_resp(sel, sel ? 1 : 4, exp_rd, exp_err, name);
    drive(sel, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    check({name, " single-cycle resp"}, 256'(get_resp(sel)), 256'(0));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, '0);
    #1;
    check_quiet(1'b0, {name, " dut4"});
    check_quiet(1'b1, {name, " dut1"});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic exp_r;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, '0);

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, '0,     '0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0060, PAT_DB, '0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0060, '0,     PAT_DB};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0260, '0,     PAT_DB};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_03E0, PAT_B,  '0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_01E0, '0,     PAT_B};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_FFE0, '0,     PAT_B};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, PAT_C,  '0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0020, '0,     '0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, '0,     PAT_C};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0060, PAT_D,  '0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0060, '0,     PAT_D};

    repeat (3) @(negedge clk);
    check_quiet(1'b0, "reset dut4");
    check_quiet(1'b1, "reset dut1");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_txn(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset two cycles into a write: no resp, no commit, store cleared.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0100, PAT_E);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    check_quiet(1'b0, "abort immediate");
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("abort resp k%0d", k), 256'(get_resp(1'b0)), 256'(0));
    end
    rst_n = 1'b1;
    do_txn(1'b0, 1'b0, 1'b1, 32'h0000_0100, '0, '0, 1'b0, "aborted write line");
    do_txn(1'b0, 1'b0, 1'b1, 32'h0000_0060, '0, '0, 1'b0, "line cleared by reset");

    // Read held high across pmem_resp: a new transaction every 5 cycles.
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0060, PAT_D, '0, 1'b0, "b2b prefill");
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0060, '0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_r = (k == 4) || (k == 9) || (k == 14);
      check($sformatf("b2b resp k%0d", k), 256'(get_resp(1'b0)), 256'(exp_r));
      check($sformatf("b2b rdata k%0d", k), get_rdata(1'b0), exp_r ? PAT_D : '0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    check("b2b idle after", 256'(get_resp(1'b0)), 256'(0));
    check("b2b err", 256'(get_err(1'b0)), 256'(0));

    // Inputs changed mid-BUSY must not disturb the latched write.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0080, PAT_F);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_00A0, PAT_G);
    wait_resp(1'b0, 3, '0, CHK, "busy change");
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    do_txn(1'b0, 1'b0, 1'b1, 32'h0000_0080, '0, PAT_F, CHK, "latched line");
    do_txn(1'b0, 1'b0, 1'b1, 32'h0000_00A0, '0, '0, CHK, "untouched line");

    // Read and write together: write wins.
    do_reset("pre rw");
    do_txn(1'b0, 1'b1, 1'b1, 32'h0000_00C0, PAT_H, '0, CHK, "rw both");
    do_txn(1'b0, 1'b0, 1'b1, 32'h0000_00C0, '0, PAT_H, CHK, "rw readback");

    // Misaligned address at acceptance.
    do_reset("pre misalign");
    do_txn(1'b0, 1'b0, 1'b1, 32'h0000_0044, '0, '0, CHK, "misaligned");

    // LATENCY=1 instance.
    do_reset("pre lat1");
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_0020, PAT_P, '0, 1'b0, "lat1 write");
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_0020, '0, PAT_P, 1'b0, "lat1 read");
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_0040, '0, '0, 1'b0, "lat1 read empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
